// File: rtl/xadc_drp_responder.sv
// XADC DRP responder model: ramping voltage/current samples, periodic eos, fixed-latency DRP.
// Define XADC_DRP_RESPONDER_WRITE_EN to make cfg0/cfg1 writable through the DRP port.
module xadc_drp_responder #(
  parameter int unsigned EOS_PERIOD  = 52,
  parameter int unsigned DRP_LATENCY = 4,
  parameter logic [15:0] RAMP_STEP   = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        den,
  input  logic        dwe,
  input  logic [6:0]  daddr,
  input  logic [15:0] di,
  output logic        drdy,
  output logic [15:0] do_out,
  output logic        eos,
  output logic        busy,
  output logic        drp_err
);

  localparam int unsigned CntW = $clog2(EOS_PERIOD);
  localparam int unsigned LatW = $clog2(DRP_LATENCY + 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(EOS_PERIOD - 1);
  localparam logic [LatW-1:0] LatLast    = LatW'(DRP_LATENCY - 1);

  localparam logic [6:0] AddrCurr = 7'h14;
  localparam logic [6:0] AddrVolt = 7'h1C;
  localparam logic [6:0] AddrCfg0 = 7'h40;
  localparam logic [6:0] AddrCfg1 = 7'h41;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;

  logic [CntW-1:0] period_q;
  logic [15:0]     volt_q, curr_q;
  logic [15:0]     cfg0, cfg1;
  logic [15:0]     rd_data, rdata_q;
  logic [1:0]      state_q, state_d;
  logic [LatW-1:0] lat_q, lat_d;
  logic            accept, ack, err_q;

  assign eos = (period_q == PeriodLast);

  // Samples move on the edge that ends the eos cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      volt_q   <= '0;
      curr_q   <= '0;
    end else begin
      period_q <= eos ? '0 : period_q + CntW'(1);
      if (eos) begin
        volt_q <= volt_q + RAMP_STEP;
        curr_q <= curr_q - RAMP_STEP;
      end
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    case (daddr)
      AddrCurr: rd_data = curr_q;
      AddrVolt: rd_data = volt_q;
      AddrCfg0: rd_data = cfg0;
      AddrCfg1: rd_data = cfg1;
      default:  rd_data = 16'h0000;
    endcase
  end

  assign accept = den && (state_q == StIdle);
  assign ack    = (state_q == StAck);
  assign busy   = (state_q != StIdle);
  assign drdy   = ack;
  assign drp_err = err_q;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      StIdle: begin
        if (den) begin
          if (DRP_LATENCY == 1) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            lat_d   = LatW'(1);
          end
        end
      end
      StWait: begin
        if (lat_q == LatLast) state_d = StAck;
        else                  lat_d   = lat_q + LatW'(1);
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (accept) rdata_q <= rd_data;
      if (den && busy) err_q <= 1'b1;
    end
  end

`ifdef XADC_DRP_RESPONDER_WRITE_EN
  logic        wr_q;
  logic [6:0]  addr_q;
  logic [15:0] di_q, cfg0_q, cfg1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      di_q   <= '0;
      cfg0_q <= '0;
      cfg1_q <= '0;
    end else begin
      if (accept) begin
        wr_q   <= dwe;
        addr_q <= daddr;
        di_q   <= di;
      end
      // Sample and unmapped addresses fall through as silent no-ops.
      if (ack && wr_q) begin
        if (addr_q == AddrCfg0) cfg0_q <= di_q;
        if (addr_q == AddrCfg1) cfg1_q <= di_q;
      end
    end
  end

  assign cfg0   = cfg0_q;
  assign cfg1   = cfg1_q;
  assign do_out = (ack && !wr_q) ? rdata_q : 16'h0000;
`else
  logic unused_wr;
  assign unused_wr = ^{dwe, di};
  assign cfg0      = 16'h0000;
  assign cfg1      = 16'h0000;
  assign do_out    = ack ? rdata_q : 16'h0000;
`endif

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Randomized bench for xadc_drp_responder against a transaction-level model, plus literal pins.
module tb_xadc_drp_responder;

  localparam int unsigned P    = 52;
  localparam int unsigned L    = 4;
  localparam logic [15:0] STEP = 16'h0010;
`ifdef XADC_DRP_RESPONDER_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [6:0]  daddr = '0;
  logic [15:0] di = '0;
  logic        drdy, eos, busy, drp_err;
  logic [15:0] do_out;

  always #5 clk = ~clk;

  xadc_drp_responder #(
    .EOS_PERIOD (P),
    .DRP_LATENCY(L),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .den    (den),
    .dwe    (dwe),
    .daddr  (daddr),
    .di     (di),
    .drdy   (drdy),
    .do_out (do_out),
    .eos    (eos),
    .busy   (busy),
    .drp_err(drp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time is counted in edges; a transaction accepted at edge e0 answers after edge e0+L-1.
  longint      edge_k = 0;
  longint      e0 = 0;
  int          t = 0;
  int          n_eos = 0;
  bit          pend = 0, m_wr = 0, m_err = 0, model_valid = 0;
  logic [6:0]  m_addr = '0;
  logic [15:0] m_di = '0, m_rdata = '0, m_cfg0 = '0, m_cfg1 = '0;

  function automatic logic [15:0] m_read(input logic [6:0] a);
    case (a)
      7'h14:   return 16'(0 - n_eos * int'(STEP));
      7'h1C:   return 16'(n_eos * int'(STEP));
      7'h40:   return m_cfg0;
      7'h41:   return m_cfg1;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic bit exp_busy();
    return pend && (edge_k <= e0 + longint'(L) - 1);
  endfunction

  function automatic bit exp_drdy();
    return pend && (edge_k == e0 + longint'(L) - 1);
  endfunction

  function automatic logic [15:0] exp_do();
    if (!exp_drdy()) return 16'h0000;
    return (WE && m_wr) ? 16'h0000 : m_rdata;
  endfunction

  task automatic model_edge();
    bit busy_in;
    edge_k++;
    if (rst) begin
      t = 0; n_eos = 0; pend = 0; m_err = 0; m_cfg0 = '0; m_cfg1 = '0;
      model_valid = 1;
      return;
    end
    if (!model_valid) return;
    busy_in = pend && (edge_k <= e0 + longint'(L));
    if (pend && edge_k == e0 + longint'(L) && WE && m_wr) begin
      if (m_addr == 7'h40) m_cfg0 = m_di;
      if (m_addr == 7'h41) m_cfg1 = m_di;
    end
    if (!busy_in) pend = 0;
    if (den) begin
      if (busy_in) m_err = 1;
      else begin
        pend = 1; e0 = edge_k; m_wr = dwe; m_addr = daddr; m_di = di;
        m_rdata = m_read(daddr);
      end
    end
    if (t % P == P - 1) n_eos++;
    t++;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("eos", eos, (t % P) == P - 1);
      check("busy", busy, exp_busy());
      check("drdy", drdy, exp_drdy());
      check("do_out", do_out, exp_do());
      check("drp_err", drp_err, m_err);
    end
  end

  // Drive inputs, take one edge, update the model; returns 2 time units after the edge.
  task automatic cycle(input bit r, input bit d, input bit w, input logic [6:0] a,
                       input logic [15:0] x);
    rst = r; den = d; dwe = w; daddr = a; di = x;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 7'h00, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int        eos_hits[$];
  int        exp_hits[3] = '{51, 103, 155};
  int        dcount;
  logic [6:0] addr_pick[4] = '{7'h14, 7'h1C, 7'h40, 7'h41};

  initial begin
    cycle(1, 1, 0, 7'h1C, 16'h0000);
    cycle(1, 0, 0, 7'h00, 16'h0000);
    check("rst_drdy", drdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_eos", eos, 1'b0);
    check("rst_do", do_out, 16'h0000);
    check("rst_err", drp_err, 1'b0);

    // c counts edges since the last reset edge; drdy after edge N+3 is cycle N+4.
    for (int c = 1; c <= 160; c++) begin
      bit         d;
      logic [6:0] a;
      d = (c == 60) || (c == 70) || (c == 120);
      a = (c == 70) ? 7'h14 : 7'h1C;
      cycle(0, d, 0, a, 16'h0000);
      if (eos) eos_hits.push_back(c);
      if (c == 62) check("lat_early", drdy, 1'b0);
      if (c == 63) begin
        check("lat_drdy", drdy, 1'b1);
        check("volt_eos1", do_out, 16'h0010);
      end
      if (c == 64) check("lat_late", drdy, 1'b0);
      if (c == 73) check("curr_wrap", do_out, 16'hFFF0);
      if (c == 123) check("volt_eos2", do_out, 16'h0020);
    end
    check("eos_hit_count", eos_hits.size(), 3);
    for (int i = 0; i < 3; i++)
      check("eos_hit_cycle", (i < eos_hits.size()) ? eos_hits[i] : -1, exp_hits[i]);

    // Write then read cfg0.
    cycle(0, 1, 1, 7'h40, 16'hA5A5);
    repeat (4) idle();
    cycle(0, 1, 0, 7'h40, 16'h0000);
    idle(); idle(); idle();
    check("wr_rb_drdy", drdy, 1'b1);
    check("wr_rb_data", do_out, WE ? 16'hA5A5 : 16'h0000);
    idle();

    // Protocol error: den at N and N+2.
    cycle(0, 1, 0, 7'h1C, 16'h0000);
    idle();
    cycle(0, 1, 0, 7'h14, 16'h0000);
    check("perr_flag", drp_err, 1'b1);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) check("perr_drdy_n4", drdy, 1'b1);
      if (drdy) dcount++;
    end
    check("perr_single_drdy", dcount, 1);

    // Reset mid-transaction: den at N, rst at N+2.
    cycle(0, 1, 0, 7'h1C, 16'h0000);
    idle();
    cycle(1, 0, 0, 7'h00, 16'h0000);
    check("rstmid_drdy", drdy, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_err", drp_err, 1'b0);
    repeat (5) idle();

    // Back-to-back: second den in the cycle right after ACK.
    cycle(0, 1, 0, 7'h1C, 16'h0000);
    idle(); idle(); idle();
    check("b2b_first_drdy", drdy, 1'b1);
    idle();
    cycle(0, 1, 0, 7'h14, 16'h0000);
    check("b2b_accept_busy", busy, 1'b1);
    idle(); idle(); idle();
    check("b2b_second_drdy", drdy, 1'b1);
    check("b2b_no_err", drp_err, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      bit         r, d, w;
      logic [6:0] a;
      r = ($urandom_range(0, 299) == 0);
      d = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 4) == 4) ? 7'($urandom) : addr_pick[$urandom_range(0, 3)];
      cycle(r, d, w, a, 16'($urandom));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_drp_responder.md
XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter EOS_PERIOD, default 52, meaning clk cycles between eos pulses (min 2).
REQ-002 SHALL have parameter DRP_LATENCY, default 4, meaning cycles from the den-sampling edge to drdy high (min 1).
REQ-003 SHALL have parameter RAMP_STEP, default 16'h0010, meaning the per-eos sample increment.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port den  input  1  DRP enable, one-cycle request strobe.
REQ-007 SHALL have port dwe  input  1  DRP write enable, qualified by den.
REQ-008 SHALL have port daddr  input  7  DRP address.
REQ-009 SHALL have port di  input  16  DRP write data.
REQ-010 SHALL have port drdy  output  1  DRP response strobe, one cycle.
REQ-011 SHALL have port do_out  output  16  DRP read data, valid only while drdy=1.
REQ-012 SHALL have port eos  output  1  end-of-sequence pulse, one cycle.
REQ-013 SHALL have port busy  output  1  high while a DRP transaction is outstanding.
REQ-014 SHALL have port drp_err  output  1  sticky flag: den received while busy.

Function
REQ-015 SHALL count a period counter 0..EOS_PERIOD-1 and wrap; eos=1 exactly in the cycle the counter equals EOS_PERIOD-1.
REQ-016 SHALL, on the edge ending each eos cycle, update voltage_sample += RAMP_STEP and current_sample -= RAMP_STEP, both modulo 2^16.
REQ-017 SHALL map addresses: 7'h14 -> current_sample (RO), 7'h1C -> voltage_sample (RO), 7'h40 -> cfg0, 7'h41 -> cfg1; all other addresses read 16'h0000.
REQ-018 SHALL implement FSM IDLE -> WAIT -> ACK -> IDLE; busy=1 in WAIT and ACK.
REQ-019 SHALL, in IDLE with den=1, latch daddr, dwe, di and the addressed register contents at that edge, then enter WAIT (or ACK directly when DRP_LATENCY=1).
REQ-020 SHALL remain in WAIT until DRP_LATENCY-1 cycles have elapsed, then assert drdy for exactly one cycle in ACK.
REQ-021 SHALL drive do_out with the latched read value in ACK for reads, 16'h0000 for writes, and 16'h0000 whenever drdy=0.
REQ-022 SHALL return the pre-update sample when den coincides with the eos update edge.
REQ-023 SHALL ignore den while busy=1 (no new transaction, no extra drdy) and set drp_err=1 until reset.
REQ-024 SHALL accept a new den in the cycle immediately after ACK (back-to-back transactions).

Reset
REQ-025 SHALL, with rst=1 at a clk edge, set the FSM to IDLE, period counter, samples, cfg0, cfg1 to 0, and drdy, do_out, eos, busy, drp_err to 0.
REQ-026 SHALL abort any outstanding transaction on reset with no drdy issued and no register write.
REQ-027 SHALL ignore den while rst=1.

Configuration
REQ-028 SHALL, with macro XADC_DRP_RESPONDER_WRITE_EN defined, write the latched di into cfg0/cfg1 on the ACK edge of a write.
REQ-029 SHALL treat writes to sample or unmapped addresses as no-ops that still complete with drdy.
REQ-030 SHALL, without XADC_DRP_RESPONDER_WRITE_EN, omit the write logic: dwe is ignored and all requests complete as reads, cfg0/cfg1 are constant 0, drdy timing is unchanged.

Verification
REQ-031 SHALL cover eos timing: default params, release reset -> eos high in cycle 51, 103, 155; voltage_sample reads 16'h0010 after first eos, 16'h0020 after second.
REQ-032 SHALL cover read latency: den=1, daddr=7'h1C at edge N -> drdy=1 only in cycle N+4, do_out=current voltage value; do_out=0 in all other cycles.
REQ-033 SHALL cover wrap-around: current_sample after the first eos reads 16'hFFF0 (0 - 16'h0010 modulo 2^16).
REQ-034 SHALL cover write/readback: with WRITE_EN, write 16'hA5A5 to 7'h40 then read 7'h40 -> do_out=16'hA5A5; without WRITE_EN -> 16'h0000.
REQ-035 SHALL cover protocol error: den at N and again at N+2 -> single drdy at N+4, drp_err=1 from N+3 onward.
REQ-036 SHALL cover reset mid-transaction: den at N, rst=1 at N+2 -> no drdy, busy=0, drp_err=0 in cycle N+3.
